// File: rtl/serial_arith_shift_ctrl_if.sv
// Operand/result handshake bundle for serial_arith_shift_ctrl.
// The master drives operands and accepts results; the slave is the shifter.
interface serial_arith_shift_ctrl_if #(
  parameter int W = 8
) ();
  localparam int SW = $clog2(W);

  logic          arg_vld;
  logic          arg_rdy;
  logic [W-1:0]  arg;
  logic [SW-1:0] shamt;
  logic          res_vld;
  logic          res_rdy;
  logic [W-1:0]  res;
  logic          busy;

  modport master (
    output arg_vld, arg, shamt, res_rdy,
    input  arg_rdy, res_vld, res, busy
  );

  modport slave (
    input  arg_vld, arg, shamt, res_rdy,
    output arg_rdy, res_vld, res, busy
  );
endinterface

// File: rtl/serial_arith_shift_ctrl.sv
// Serial signed divide-by-2^shamt: one arithmetic right shift per cycle.
// Define SERIAL_ARITH_SHIFT_ROUND_TO_ZERO_EN for truncating (C-style) rounding.
//
// state | meaning
// IDLE  | ready for an operand
// SHIFT | one 1-bit arithmetic shift per cycle, cnt_q shifts remaining
// DONE  | result presented, waiting for res_rdy
module serial_arith_shift_ctrl #(
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_arith_shift_ctrl_if.slave  bus
);
  localparam int SW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (bus.arg_vld) begin
          shreg_d  = bus.arg;
          cnt_d    = bus.shamt;
          sticky_d = 1'b0;
          state_d  = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // sticky collects every bit shifted out, for the rounding correction
        shreg_d  = {shreg_q[W-1], shreg_q[W-1:1]};
        sticky_d = sticky_q | shreg_q[0];
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.arg_rdy = (state_q == IDLE);
  assign bus.res_vld = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);

`ifdef SERIAL_ARITH_SHIFT_ROUND_TO_ZERO_EN
  // floor result of a negative operand is one below truncation when bits were lost
  assign bus.res = shreg_q + W'(shreg_q[W-1] & sticky_q);
`else
  assign bus.res = shreg_q;
`endif

endmodule

// File: tb/tb_serial_arith_shift_ctrl.sv
// Scoreboard bench for serial_arith_shift_ctrl: random and directed operands,
// backpressure and mid-operation reset, checked against an integer division model.
module tb_serial_arith_shift_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_arith_shift_ctrl_if #(.W(W)) bus ();

  serial_arith_shift_ctrl #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    int           edge_n;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_done   = 0;
  bit   force_stall = 1'b0;
  bit   prev_vld = 1'b0;
  bit   holding  = 1'b0;
  bit   hs_prev  = 1'b0;
  logic [W-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // arg / 2^s as plain integer arithmetic: floor, or truncation when rounding is on
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input int s);
    int av;
    int d;
    int q;
    av = $signed(a);
    d  = 1 << s;
    q  = av / d;
`ifndef SERIAL_ARITH_SHIFT_ROUND_TO_ZERO_EN
    if (av < 0 && (av % d) != 0) q = q - 1;
`endif
    return q[W-1:0];
  endfunction

  // monitor: decides res_rdy for the coming edge and checks what the DUT presents
  always @(negedge clk) begin
    if (rst) begin
      prev_vld    = 1'b0;
      holding     = 1'b0;
      hs_prev     = 1'b0;
      bus.res_rdy = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("idle_after_hs_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_after_hs_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
      end
      if (holding) begin
        chk("bp_res_vld", {31'd0, bus.res_vld}, 32'd1);
        chk("bp_res_stable", {24'd0, bus.res}, {24'd0, held});
      end
      if (bus.res_vld && !prev_vld) begin
        if (sbq.size() == 0) chk("unexpected_result", sbq.size(), 32'd1);
        else chk("latency", cyc, sbq[0].edge_n);
      end
      if (bus.res_vld) begin
        chk("done_arg_rdy", {31'd0, bus.arg_rdy}, 32'd0);
        chk("done_busy", {31'd0, bus.busy}, 32'd1);
      end
      bus.res_rdy = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
      hs_prev = 1'b0;
      holding = 1'b0;
      if (bus.res_vld) begin
        if (bus.res_rdy) begin
          if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("result", {24'd0, bus.res}, {24'd0, e.res});
          end
          n_done++;
          hs_prev = 1'b1;
        end else begin
          holding = 1'b1;
          held    = bus.res;
        end
      end
      prev_vld = bus.res_vld;
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [2:0] s,
                       input bit use_c, input logic [W-1:0] cv);
    int   waitc;
    exp_t e;
    waitc = 0;
    @(negedge clk);
    while (!bus.arg_rdy && waitc < 300) begin
      bus.arg_vld = 1'($urandom_range(0, 1));
      bus.arg     = 8'($urandom);
      bus.shamt   = 3'($urandom);
      @(negedge clk);
      waitc++;
    end
    if (!bus.arg_rdy) begin
      chk("accept_timeout", {31'd0, bus.arg_rdy}, 32'd1);
      bus.arg_vld = 1'b0;
      return;
    end
    bus.arg_vld = 1'b1;
    bus.arg     = a;
    bus.shamt   = s;
    e.res    = use_c ? cv : ref_div(a, int'(s));
    e.edge_n = cyc + 1 + int'(s);
    sbq.push_back(e);
    @(negedge clk);
    bus.arg_vld = 1'b0;
    bus.arg     = 8'($urandom);
    bus.shamt   = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) chk("drain_timeout", sbq.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    exp_t e;
    rst         = 1'b1;
    bus.arg_vld = 1'b0;
    bus.arg     = '0;
    bus.shamt   = '0;
    repeat (3) @(negedge clk);
    chk("rst_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    chk("rst_res_vld", {31'd0, bus.res_vld}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_res", {24'd0, bus.res}, 32'd0);
    rst = 1'b0;

    do_op(8'hB4, 3'd2, 1'b1, 8'hED);
`ifdef SERIAL_ARITH_SHIFT_ROUND_TO_ZERO_EN
    do_op(8'h91, 3'd3, 1'b1, 8'hF3);
`else
    do_op(8'h91, 3'd3, 1'b1, 8'hF2);
`endif
    do_op(8'h80, 3'd7, 1'b1, 8'hFF);
    do_op(8'h7F, 3'd7, 1'b1, 8'h00);
    do_op(8'h5A, 3'd0, 1'b1, 8'h5A);
    drain();

    for (int i = 0; i < 40; i++) do_op(8'($urandom), 3'($urandom), 1'b0, 8'h00);
    drain();

    // backpressure: hold res_rdy low, pulse arg_vld into a busy unit
    force_stall = 1'b1;
    do_op(8'hC3, 3'd4, 1'b0, 8'h00);
    n = 0;
    while (!bus.res_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", {31'd0, bus.res_vld}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.arg_vld = ~bus.arg_vld;
      bus.arg     = 8'($urandom);
      bus.shamt   = 3'($urandom);
      @(negedge clk);
    end
    bus.arg_vld = 1'b0;
    force_stall = 1'b0;
    drain();

    // reset two shifts into an operation
    do_op(8'h91, 3'd5, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("midrst_res_vld", {31'd0, bus.res_vld}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_arg_rdy", {31'd0, bus.arg_rdy}, 32'd1);
    chk("midrst_res", {24'd0, bus.res}, 32'd0);
    @(negedge clk);
    bus.arg_vld = 1'b1;
    bus.arg     = 8'h40;
    bus.shamt   = 3'd3;
    @(negedge clk);
    rst      = 1'b0;
    e.res    = 8'h08;
    e.edge_n = cyc + 1 + 3;
    sbq.push_back(e);
    @(negedge clk);
    bus.arg_vld = 1'b0;
    drain();

    for (int i = 0; i < 15; i++) do_op(8'($urandom), 3'($urandom), 1'b0, 8'h00);
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_arith_shift_ctrl.md
# serial_arith_shift_ctrl

- Multi-cycle signed divide-by-power-of-2 unit.
- Accepts a W-bit two's-complement operand and a runtime shift amount over a valid/ready handshake.
- Sequences a single 1-bit arithmetic-right-shift stage once per cycle, then presents the result on a second valid/ready handshake.
- Serves as the shared, area-minimal alternative to a full barrel shifter in arithmetic pipelines, with optional round-toward-zero correction.

## Interface

Parameters:
- W, 8, operand/result width; power of two, ≥ 2.
- SW, $clog2(W), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- arg_vld  input  1  operand valid.
- arg_rdy  output  1  unit can accept an operand.
- arg  input  W  signed operand.
- shamt  input  SW  shift amount, 0..W-1.
- res_vld  output  1  result valid.
- res_rdy  input  1  downstream accepts result.
- res  output  W  signed result.
- busy  output  1  unit holds an operation (not IDLE).

## Operation

FSM states:
- IDLE: arg_rdy=1.
  - On arg_vld&&arg_rdy, latch arg into shreg, shamt into cnt, and clear sticky.
  - Next state: SHIFT if shamt≠0, else DONE.
- SHIFT: each cycle:
  - shreg ← {shreg[W-1], shreg[W-1:1]}.
  - sticky ← sticky | shreg[0].
  - cnt ← cnt-1.
  - When cnt==1 at the edge, next state is DONE.
- DONE: res_vld=1. On res_vld&&res_rdy, next state is IDLE.

Outputs and input handling:
- res is driven from registers only; no combinational path from any input to any output.
- arg_rdy is high only in IDLE. arg_vld, arg and shamt are ignored in SHIFT and DONE.
- busy = (state≠IDLE).
- res_vld is high only in DONE. res and res_vld stay stable while res_rdy is low.
- res is meaningful only while res_vld=1; elsewhere it shows the current shreg-derived value.

## Timing

- Reset values (immediately on rst assertion, held until deassertion):
  - state=IDLE, arg_rdy=1, res_vld=0, busy=0, res=0.
  - shreg, cnt and sticky are all zero.
- Latency: res_vld rises in the cycle after the shamt-th rising edge following the accepting edge.
  - shamt=0: res_vld is high in the cycle immediately after acceptance.
- Throughput: one operation per shamt+2 cycles minimum (accept, shamt shifts, result handshake, re-enter IDLE). No overlap between result handshake and next accept.
- Boundary conditions:
  - shamt=W-1: result is 0 for non-negative operands and −1 for negative operands (without rounding).
  - Backpressure: DONE persists indefinitely while res_rdy=0. Nothing is lost or altered.
  - Reset mid-SHIFT or mid-DONE: the operation is discarded and no result is emitted. The next accept after release behaves normally.
  - arg_vld asserted during reset release: accept on the first edge with rst low.

## Configuration

- Macro `SERIAL_ARITH_SHIFT_ROUND_TO_ZERO_EN`.
- Defined: res = shreg + (shreg[W-1] & sticky), computed from registers.
  - Negative operands with nonzero discarded bits are corrected upward by 1.
  - Result equals C-style truncating signed division arg / 2^shamt.
- Undefined: res = shreg, i.e. exactly arg >>> shamt (floor division).
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan

All cases use W=8.

- arg=8'hB4 (−76), shamt=2 → res=8'hED (−19) in both builds; res_vld rises 2 edges after accept.
- arg=8'h91 (−111), shamt=3 → res=8'hF2 (−14) without macro, 8'hF3 (−13) with macro.
- arg=8'h80, shamt=7 → 8'hFF. arg=8'h7F, shamt=7 → 8'h00. Same in both builds.
- arg=8'h5A, shamt=0 → res=8'h5A, res_vld high in the cycle right after acceptance.
- Backpressure:
  - Hold res_rdy=0 for 5 cycles in DONE: res_vld=1 and res stay constant, arg_rdy=0, busy=1.
  - arg_vld pulses during that time are ignored.
  - Releasing res_rdy returns the unit to IDLE on the next edge.
- Reset mid-operation:
  - Accept arg=8'h91, shamt=5, and assert rst after 2 shifts: res_vld=0, busy=0, arg_rdy=1 immediately.
  - After release, arg=8'h40, shamt=3 → 8'h08.
